// File: rtl/axi4_burst_mem_slave_if.sv
// AXI4 full-protocol bus bundle (AW/W/B/AR/R) between a burst master and the memory slave.
interface axi4_burst_mem_slave_if #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32
);
  logic [C_S_AXI_ID_WIDTH-1:0]     awid;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                      awlen;
  logic [2:0]                      awsize;
  logic [1:0]                      awburst;
  logic                            awvalid;
  logic                            awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                            wlast;
  logic                            wvalid;
  logic                            wready;
  logic [C_S_AXI_ID_WIDTH-1:0]     bid;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;
  logic [C_S_AXI_ID_WIDTH-1:0]     arid;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                      arlen;
  logic [2:0]                      arsize;
  logic [1:0]                      arburst;
  logic                            arvalid;
  logic                            arready;
  logic [C_S_AXI_ID_WIDTH-1:0]     rid;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                      rresp;
  logic                            rlast;
  logic                            rvalid;
  logic                            rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 INCR-burst memory slave with independent write (AW/W/B) and read (AR/R) engines
// over a word-organised RAM; out-of-range beats answer DECERR, bad burst/size answer SLVERR.
module axi4_burst_mem_slave #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_MEM_DEPTH_WORDS  = 256
) (
  input logic                  ACLK,
  input logic                  ARESET,
  axi4_burst_mem_slave_if.slave s_axi
);
  localparam int unsigned StrbW     = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned ByteShift = $clog2(StrbW);
  localparam int unsigned MemAw     = $clog2(C_MEM_DEPTH_WORDS);
  // One spare bit so a burst running past the top of the address space still reads as out of range
  localparam int unsigned IdxW      = C_S_AXI_ADDR_WIDTH + 1;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;
  localparam logic [1:0]  RespDecerr = 2'b11;
  localparam logic [1:0]  BurstIncr  = 2'b01;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [C_MEM_DEPTH_WORDS];

  // Write engine
  w_state_e                    r_w_state, w_w_state_nxt;
  logic [C_S_AXI_ID_WIDTH-1:0] r_w_id, w_w_id_nxt;
  logic [IdxW-1:0]             r_w_idx, w_w_idx_nxt;
  logic [7:0]                  r_w_len, w_w_len_nxt;
  logic [8:0]                  r_w_cnt, w_w_cnt_nxt;
  logic                        r_w_slv, w_w_slv_nxt;
  logic [1:0]                  r_w_resp, w_w_resp_nxt;
  logic                        w_w_addr_ok, w_w_in_len, w_w_at_len, w_mem_we;
  logic [1:0]                  w_beat_err;

  assign w_w_addr_ok = (r_w_idx < IdxW'(C_MEM_DEPTH_WORDS));
  assign w_w_in_len  = (r_w_cnt <= {1'b0, r_w_len});
  assign w_w_at_len  = (r_w_cnt == {1'b0, r_w_len});

  always_comb begin
    w_w_state_nxt = r_w_state;
    w_w_id_nxt    = r_w_id;
    w_w_idx_nxt   = r_w_idx;
    w_w_len_nxt   = r_w_len;
    w_w_cnt_nxt   = r_w_cnt;
    w_w_slv_nxt   = r_w_slv;
    w_w_resp_nxt  = r_w_resp;
    w_mem_we      = 1'b0;
    // DECERR is encoded numerically above SLVERR, so "worst" is a plain max
    w_beat_err    = RespOkay;
    if (s_axi.wlast != w_w_at_len) w_beat_err = RespSlverr;
    if (w_w_in_len && !w_w_addr_ok) w_beat_err = RespDecerr;
    unique case (r_w_state)
      WIdle: begin
        if (s_axi.awvalid) begin
          w_w_state_nxt = WData;
          w_w_id_nxt    = s_axi.awid;
          w_w_idx_nxt   = IdxW'(s_axi.awaddr >> ByteShift);
          w_w_len_nxt   = s_axi.awlen;
          w_w_cnt_nxt   = '0;
          w_w_slv_nxt   = (s_axi.awburst != BurstIncr) || (s_axi.awsize != 3'(ByteShift));
          w_w_resp_nxt  = w_w_slv_nxt ? RespSlverr : RespOkay;
        end
      end
      WData: begin
        if (s_axi.wvalid) begin
          w_mem_we    = w_w_in_len && w_w_addr_ok && !r_w_slv;
          w_w_idx_nxt = r_w_idx + IdxW'(1);
          if (w_w_in_len) w_w_cnt_nxt = r_w_cnt + 9'd1;
          if (w_beat_err > r_w_resp) w_w_resp_nxt = w_beat_err;
          if (s_axi.wlast) w_w_state_nxt = WResp;
        end
      end
      WResp: begin
        if (s_axi.bready) w_w_state_nxt = WIdle;
      end
      default: w_w_state_nxt = WIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_w_state <= WIdle;
      r_w_id    <= '0;
      r_w_idx   <= '0;
      r_w_len   <= '0;
      r_w_cnt   <= '0;
      r_w_slv   <= 1'b0;
      r_w_resp  <= RespOkay;
    end else begin
      r_w_state <= w_w_state_nxt;
      r_w_id    <= w_w_id_nxt;
      r_w_idx   <= w_w_idx_nxt;
      r_w_len   <= w_w_len_nxt;
      r_w_cnt   <= w_w_cnt_nxt;
      r_w_slv   <= w_w_slv_nxt;
      r_w_resp  <= w_w_resp_nxt;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET && w_mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (s_axi.wstrb[b]) r_mem[r_w_idx[MemAw-1:0]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  assign s_axi.awready = (r_w_state == WIdle);
  assign s_axi.wready  = (r_w_state == WData);
  assign s_axi.bvalid  = (r_w_state == WResp);
  assign s_axi.bid     = r_w_id;
  assign s_axi.bresp   = r_w_resp;

  // Read engine: R registers always hold the beat on offer; each handshake preloads the next word
  r_state_e                      r_r_state, w_r_state_nxt;
  logic [C_S_AXI_ID_WIDTH-1:0]   r_r_id, w_r_id_nxt;
  logic [IdxW-1:0]               r_r_idx, w_r_idx_nxt;
  logic [7:0]                    r_r_len, w_r_len_nxt;
  logic [7:0]                    r_r_cnt, w_r_cnt_nxt;
  logic                          r_r_slv, w_r_slv_nxt;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic [1:0]                    r_rresp, w_rresp_nxt;
  logic                          r_rlast, w_rlast_nxt;
  logic [IdxW-1:0]               w_ar_idx, w_ld_idx;
  logic                          w_ar_slv, w_ld_slv, w_ld_ok;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_ld_data;
  logic [1:0]                    w_ld_resp;

  assign w_ar_idx  = IdxW'(s_axi.araddr >> ByteShift);
  assign w_ar_slv  = (s_axi.arburst != BurstIncr) || (s_axi.arsize != 3'(ByteShift));
  assign w_ld_idx  = (r_r_state == RIdle) ? w_ar_idx : r_r_idx;
  assign w_ld_slv  = (r_r_state == RIdle) ? w_ar_slv : r_r_slv;
  assign w_ld_ok   = (w_ld_idx < IdxW'(C_MEM_DEPTH_WORDS));
  assign w_ld_data = w_ld_ok ? r_mem[w_ld_idx[MemAw-1:0]] : '0;
  assign w_ld_resp = !w_ld_ok ? RespDecerr : (w_ld_slv ? RespSlverr : RespOkay);

  always_comb begin
    w_r_state_nxt = r_r_state;
    w_r_id_nxt    = r_r_id;
    w_r_idx_nxt   = r_r_idx;
    w_r_len_nxt   = r_r_len;
    w_r_cnt_nxt   = r_r_cnt;
    w_r_slv_nxt   = r_r_slv;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    w_rlast_nxt   = r_rlast;
    unique case (r_r_state)
      RIdle: begin
        if (s_axi.arvalid) begin
          w_r_state_nxt = RData;
          w_r_id_nxt    = s_axi.arid;
          w_r_len_nxt   = s_axi.arlen;
          w_r_cnt_nxt   = '0;
          w_r_slv_nxt   = w_ar_slv;
          w_r_idx_nxt   = w_ar_idx + IdxW'(1);
          w_rdata_nxt   = w_ld_data;
          w_rresp_nxt   = w_ld_resp;
          w_rlast_nxt   = (s_axi.arlen == 8'd0);
        end
      end
      RData: begin
        if (s_axi.rready) begin
          if (r_rlast) begin
            w_r_state_nxt = RIdle;
            w_rlast_nxt   = 1'b0;
          end else begin
            w_r_cnt_nxt = r_r_cnt + 8'd1;
            w_r_idx_nxt = r_r_idx + IdxW'(1);
            w_rdata_nxt = w_ld_data;
            w_rresp_nxt = w_ld_resp;
            w_rlast_nxt = ((r_r_cnt + 8'd1) == r_r_len);
          end
        end
      end
      default: w_r_state_nxt = RIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_r_state <= RIdle;
      r_r_id    <= '0;
      r_r_idx   <= '0;
      r_r_len   <= '0;
      r_r_cnt   <= '0;
      r_r_slv   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RespOkay;
      r_rlast   <= 1'b0;
    end else begin
      r_r_state <= w_r_state_nxt;
      r_r_id    <= w_r_id_nxt;
      r_r_idx   <= w_r_idx_nxt;
      r_r_len   <= w_r_len_nxt;
      r_r_cnt   <= w_r_cnt_nxt;
      r_r_slv   <= w_r_slv_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
      r_rlast   <= w_rlast_nxt;
    end
  end

  assign s_axi.arready = (r_r_state == RIdle);
  assign s_axi.rvalid  = (r_r_state == RData);
  assign s_axi.rid     = r_r_id;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rlast   = r_rlast;
endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Randomised bench for axi4_burst_mem_slave: a word-array memory model predicts every R beat and
// B response; a negedge monitor checks the DUT against those predictions whenever valid is high.
module tb_axi4_burst_mem_slave;
  localparam int unsigned IdW   = 1;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned Depth = 256;

  logic ACLK   = 1'b0;
  logic ARESET = 1'b1;

  axi4_burst_mem_slave_if #(
    .C_S_AXI_ID_WIDTH  (IdW),
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW)
  ) bus ();

  axi4_burst_mem_slave #(
    .C_S_AXI_ID_WIDTH  (IdW),
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_MEM_DEPTH_WORDS (Depth)
  ) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .s_axi (bus)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [0:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct packed {
    logic [0:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] m_mem [Depth];
  logic [31:0] td [300];
  logic [3:0]  ts [300];
  int          n_vec = 0;
  int          n_err = 0;
  bit          r_b2b = 1'b0;
  bit          r_started = 1'b0;
  logic [1:0]  resp;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return bus.awready;
      1:       return bus.wready;
      default: return bus.arready;
    endcase
  endfunction

  // Returns at posedge+1 just after the handshake edge
  task automatic wait_hs(input string name, input int sel);
    for (int t = 0; t < 1000; t++) begin
      @(negedge ACLK);
      if (rdy(sel)) begin
        @(posedge ACLK);
        #1;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL %s_timeout: no ready within 1000 cycles, expected handshake", name);
  endtask

  // Reference: whole-burst effect on memory and the worst response
  function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int nbeats);
    logic [1:0]  r = 2'b00;
    bit          slv;
    int unsigned idx;
    slv = (burst != 2'b01) || (size != 3'd2);
    if (slv || nbeats != len + 1) r = 2'b10;
    for (int i = 0; i < nbeats && i <= len; i++) begin
      idx = (addr >> 2) + i;
      if (idx >= Depth) r = 2'b11;
      else if (!slv) begin
        for (int b = 0; b < 4; b++) if (ts[i][b]) m_mem[idx][8*b +: 8] = td[i][8*b +: 8];
      end
    end
    return r;
  endfunction

  task automatic aw_req(input logic [0:0] id, input logic [31:0] addr, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    bus.awid    = id;
    bus.awaddr  = addr;
    bus.awlen   = 8'(len);
    bus.awsize  = size;
    bus.awburst = burst;
    bus.awvalid = 1'b1;
    wait_hs("aw", 0);
    bus.awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last);
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wlast  = last;
    bus.wvalid = 1'b1;
    wait_hs("w", 1);
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic b_wait(input int hold);
    int t;
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      chk("bvalid_held", bus.bvalid, 1);
      chk("awready_low_in_b", bus.awready, 0);
    end
    @(posedge ACLK);
    #1 bus.bready = 1'b1;
    for (t = 0; t < 1000; t++) begin
      @(posedge ACLK);
      if (bq.size() == 0) break;
    end
    if (t == 1000) begin
      n_vec++;
      n_err++;
      $display("FAIL b_timeout: %0d responses outstanding, expected 0", bq.size());
      bq.delete();
    end
    #1 bus.bready = 1'b0;
    @(negedge ACLK);
    chk("awready_after_b", bus.awready, 1);
  endtask

  task automatic wr(input logic [0:0] id, input logic [31:0] addr, input int len,
                    input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                    input int bhold, output logic [1:0] exp_resp);
    exp_resp = model_write(addr, len, size, burst, nbeats);
    bq.push_back(bexp_t'{id: id, resp: exp_resp});
    aw_req(id, addr, len, size, burst);
    for (int i = 0; i < nbeats; i++) w_beat(td[i], ts[i], i == nbeats - 1);
    @(negedge ACLK);
    chk("bvalid_after_wlast", bus.bvalid, 1);
    chk("wready_after_wlast", bus.wready, 0);
    b_wait(bhold);
    @(posedge ACLK);
    #1;
  endtask

  // mode 0: RREADY always high, 1: random, 2: repeating 1,0,0,1
  task automatic rd(input logic [0:0] id, input logic [31:0] addr, input int len,
                    input logic [2:0] size, input logic [1:0] burst, input int mode);
    bit          slv;
    int unsigned idx;
    rbeat_t      e;
    slv = (burst != 2'b01) || (size != 3'd2);
    for (int i = 0; i <= len; i++) begin
      idx    = (addr >> 2) + i;
      e.id   = id;
      e.data = (idx < Depth) ? m_mem[idx] : 32'h0;
      e.resp = (idx >= Depth) ? 2'b11 : (slv ? 2'b10 : 2'b00);
      e.last = (i == len);
      rq.push_back(e);
    end
    r_b2b       = (mode == 0);
    r_started   = 1'b0;
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = 8'(len);
    bus.arsize  = size;
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    wait_hs("ar", 2);
    bus.arvalid = 1'b0;
    for (int t = 0; ; t++) begin
      case (mode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = 1'($urandom_range(0, 1));
        default: bus.rready = (t % 4 == 0) || (t % 4 == 3);
      endcase
      @(posedge ACLK);
      if (rq.size() == 0) break;
      #1;
      if (t > 3000) begin
        n_vec++;
        n_err++;
        $display("FAIL r_timeout: %0d beats outstanding, expected 0", rq.size());
        rq.delete();
        break;
      end
    end
    #1 bus.rready = 1'b0;
    r_b2b = 1'b0;
    @(negedge ACLK);
    chk("rvalid_after_rlast", bus.rvalid, 0);
    chk("arready_after_rlast", bus.arready, 1);
    @(posedge ACLK);
    #1;
  endtask

  // Monitor: whenever a valid is up, the offered beat must equal the oldest prediction
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        if (r_b2b && r_started && rq.size() > 0) chk("r_back_to_back", bus.rvalid, 1);
        if (bus.rvalid) begin
          r_started = 1'b1;
          if (rq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL r_unexpected: RVALID=1 rdata=0x%0h, expected no beat", bus.rdata);
          end else begin
            chk("r_beat{id,data,resp,last}", {bus.rid, bus.rdata, bus.rresp, bus.rlast}, rq[0]);
            if (bus.rready) void'(rq.pop_front());
          end
        end
        if (bus.bvalid) begin
          if (bq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL b_unexpected: BVALID=1 bresp=%0d, expected no response", bus.bresp);
          end else begin
            chk("b_resp{id,resp}", {bus.bid, bus.bresp}, bq[0]);
            if (bus.bready) void'(bq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_awready", bus.awready, 1);
    chk("rst_arready", bus.arready, 1);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rlast", bus.rlast, 0);
    chk("rst_bresp_bid", {bus.bresp, bus.bid}, 0);
    chk("rst_rresp_rid_rdata", {bus.rresp, bus.rid, bus.rdata}, 0);
    @(posedge ACLK);
    #1;

    // Fill the whole RAM with one maximum-length burst so every word is known
    for (int i = 0; i < 256; i++) begin td[i] = $urandom; ts[i] = 4'hF; end
    wr(1'b0, 32'h0, 255, 3'd2, 2'b01, 256, 0, resp);

    // 8-beat write of 1..8 and back-to-back readback
    for (int i = 0; i < 8; i++) begin td[i] = 32'(i + 1); ts[i] = 4'hF; end
    wr(1'b1, 32'h0, 7, 3'd2, 2'b01, 8, 0, resp);
    chk("model_okay_resp", resp, 2'b00);
    chk("model_word3", m_mem[3], 32'h4);
    rd(1'b1, 32'h0, 7, 3'd2, 2'b01, 0);

    // Partial-strobe merge
    td[0] = 32'hAABBCCDD; ts[0] = 4'hF;
    wr(1'b0, 32'h10, 0, 3'd2, 2'b01, 1, 0, resp);
    td[0] = 32'h11223344; ts[0] = 4'h3;
    wr(1'b0, 32'h10, 0, 3'd2, 2'b01, 1, 1, resp);
    chk("model_strobe_merge", m_mem[4], 32'hAABB3344);
    rd(1'b0, 32'h10, 0, 3'd2, 2'b01, 0);

    // Burst crossing the top of memory
    rd(1'b0, (Depth - 2) * 4, 3, 3'd2, 2'b01, 0);
    for (int i = 0; i < 4; i++) begin td[i] = $urandom; ts[i] = 4'hF; end
    wr(1'b1, (Depth - 2) * 4, 3, 3'd2, 2'b01, 4, 0, resp);
    chk("model_decerr_resp", resp, 2'b11);
    rd(1'b1, (Depth - 2) * 4, 3, 3'd2, 2'b01, 2);

    // Stalled B and stalled R
    for (int i = 0; i < 8; i++) begin td[i] = $urandom; ts[i] = 4'hF; end
    wr(1'b0, 32'h40, 7, 3'd2, 2'b01, 8, 5, resp);
    rd(1'b0, 32'h40, 7, 3'd2, 2'b01, 2);

    // Early WLAST, WRAP burst, wrong size
    for (int i = 0; i < 8; i++) begin td[i] = $urandom; ts[i] = 4'hF; end
    wr(1'b1, 32'h60, 7, 3'd2, 2'b01, 3, 0, resp);
    chk("model_early_wlast", resp, 2'b10);
    wr(1'b0, 32'h60, 3, 3'd2, 2'b10, 4, 0, resp);
    chk("model_wrap_slverr", resp, 2'b10);
    wr(1'b0, 32'h60, 1, 3'd1, 2'b01, 2, 0, resp);
    rd(1'b0, 32'h60, 7, 3'd2, 2'b01, 0);
    rd(1'b1, 32'h60, 3, 3'd2, 2'b10, 1);

    // Reset during beat 4 of an 8-beat write
    for (int i = 0; i < 4; i++) begin td[i] = $urandom; ts[i] = 4'hF; end
    aw_req(1'b0, 32'h80, 7, 3'd2, 2'b01);
    for (int i = 0; i < 3; i++) begin
      m_mem[32 + i] = td[i];
      w_beat(td[i], 4'hF, 1'b0);
    end
    bus.wdata  = td[3];
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    ARESET     = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET     = 1'b0;
    bus.wvalid = 1'b0;
    @(negedge ACLK);
    chk("midrst_bvalid", bus.bvalid, 0);
    chk("midrst_wready", bus.wready, 0);
    chk("midrst_awready", bus.awready, 1);
    @(posedge ACLK);
    #1;
    rd(1'b0, 32'h80, 7, 3'd2, 2'b01, 0);
    for (int i = 0; i < 4; i++) begin td[i] = $urandom; ts[i] = 4'hF; end
    wr(1'b1, 32'h80, 3, 3'd2, 2'b01, 4, 0, resp);
    rd(1'b1, 32'h80, 3, 3'd2, 2'b01, 1);

    // Randomised mix
    for (int n = 0; n < 40; n++) begin
      int unsigned len, word, nb;
      logic [2:0]  sz;
      logic [1:0]  bt;
      logic [31:0] a;
      len  = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 64) : $urandom_range(0, 7);
      word = $urandom_range(0, Depth + 2);
      a    = word * 4 + $urandom_range(0, 3);
      bt   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b01;
      sz   = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
      if ($urandom_range(0, 1) == 1) begin
        nb = len + 1;
        if ($urandom_range(0, 7) == 0) nb = $urandom_range(1, len + 3);
        for (int i = 0; i < 300; i++) begin td[i] = $urandom; ts[i] = 4'($urandom); end
        wr(1'($urandom), a, int'(len), sz, bt, int'(nb), int'($urandom_range(0, 3)), resp);
      end else begin
        rd(1'($urandom), a, int'(len), sz, bt, int'($urandom_range(0, 2)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
